// File: rtl/uart_tx_scheduler.sv
// Round-robin packet scheduler in front of a single UART transmitter.
// Frames each granted packet as header, payload bytes and a checksum trailer.
module uart_tx_scheduler #(
   parameter int unsigned NUM_REQ       = 4,
   parameter logic [3:0]  HDR_TAG       = 4'hA,
   parameter int unsigned STALL_TIMEOUT = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_en,
   input  logic                 tx_finish,
   output logic                 busy,
   output logic [3:0]           grant_id,
   output logic                 pkt_done,
   output logic                 pkt_abort
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] HDR      = 3'd1;
   localparam logic [2:0] WAIT_HDR = 3'd2;
   localparam logic [2:0] FETCH    = 3'd3;
   localparam logic [2:0] LAUNCH   = 3'd4;
   localparam logic [2:0] WAIT_PAY = 3'd5;
   localparam logic [2:0] SUM      = 3'd6;
   localparam logic [2:0] WAIT_SUM = 3'd7;

   localparam logic [4:0] NREQ = 5'(NUM_REQ);

   logic [2:0]         state;
   logic [3:0]         rr_ptr;
   logic [7:0]         sum;
   logic [7:0]         pay_byte;
   logic               pay_last;
   logic               abort;
   logic [7:0]         tx_hold;
   logic [7:0]         launch_byte;
   logic [15:0]        stall_cnt;
   logic [16:0]        stall_nxt;
   logic               stall_hit;
   logic               pick_found;
   logic [3:0]         pick_id;
   logic [4:0]         idx;
   logic [NUM_REQ-1:0] vshift;
   logic [4:0]         next_rr;
   logic [7:0]         cur_byte;
   logic [NUM_REQ-1:0] cur_vsh;
   logic [NUM_REQ-1:0] cur_lsh;

   // Round-robin pick: first valid source at or after rr_ptr
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      idx        = '0;
      vshift     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_ptr} + 5'(k);
         if (idx >= NREQ) idx = idx - NREQ;
         vshift = req_valid >> idx;
         if (!pick_found && vshift[0]) begin
            pick_found = 1'b1;
            pick_id    = idx[3:0];
         end
      end
   end

   assign cur_byte  = 8'(req_data >> {grant_id, 3'b000});
   assign cur_vsh   = req_valid >> grant_id;
   assign cur_lsh   = req_last >> grant_id;
   assign stall_nxt = {1'b0, stall_cnt} + 17'd1;
   assign stall_hit = (STALL_TIMEOUT != 0) &&
                      (stall_nxt == 17'(STALL_TIMEOUT));
   assign next_rr   = {1'b0, grant_id} + 5'd1;

   assign busy      = (state != IDLE);
   assign tx_en     = (state == HDR) || (state == LAUNCH) ||
                      (state == SUM);
   assign req_ready = (state == FETCH) ? (NUM_REQ'(1) << grant_id) : '0;
   assign tx_data   = launch_byte;

   // Byte presented to the UART; holds the last launched value otherwise
   always_comb begin
      launch_byte = tx_hold;
      case (state)
         HDR:     launch_byte = {HDR_TAG, grant_id};
         LAUNCH:  launch_byte = pay_byte;
         SUM:     launch_byte = abort ? ~sum : sum;
         default: launch_byte = tx_hold;
      endcase
   end

   // Packet framing FSM, checksum, stall timer and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         sum       <= '0;
         pay_byte  <= '0;
         pay_last  <= 1'b0;
         abort     <= 1'b0;
         tx_hold   <= '0;
         stall_cnt <= '0;
         pkt_done  <= 1'b0;
         pkt_abort <= 1'b0;
      end else begin
         pkt_done  <= 1'b0;
         pkt_abort <= 1'b0;
         if (tx_en) tx_hold <= launch_byte;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_id;
                  state    <= HDR;
               end
            end
            HDR: begin
               sum   <= {HDR_TAG, grant_id};
               state <= WAIT_HDR;
            end
            WAIT_HDR: begin
               if (tx_finish) begin
                  stall_cnt <= '0;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               if (cur_vsh[0]) begin
                  pay_byte <= cur_byte;
                  pay_last <= cur_lsh[0];
                  sum      <= sum + cur_byte;
                  state    <= LAUNCH;
               end else begin
                  stall_cnt <= stall_nxt[15:0];
                  if (stall_hit) begin
                     abort <= 1'b1;
                     state <= SUM;
                  end
               end
            end
            LAUNCH: state <= WAIT_PAY;
            WAIT_PAY: begin
               if (tx_finish) begin
                  stall_cnt <= '0;
                  state     <= pay_last ? SUM : FETCH;
               end
            end
            SUM: state <= WAIT_SUM;
            WAIT_SUM: begin
               if (tx_finish) begin
                  pkt_done  <= ~abort;
                  pkt_abort <= abort;
                  abort     <= 1'b0;
                  rr_ptr    <= (next_rr >= NREQ) ? 4'd0 : next_rr[3:0];
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
